// File: rtl/ttl_74193_seq_pkg.sv
// Shared definitions for the 74193 command sequencer.
// Holds the command opcode encoding used on cmd_op and the sequencer
// state enumeration shared by the top level and the testbench.
package ttl_74193_seq_pkg;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;
    localparam logic [1:0] OP_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HIGH  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/ttl_74193_seq_phase_timer.sv
// Loadable down-counter that times the LOW and HIGH phases of a count pulse.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   load     - load load_val this cycle (start of a new phase)
//   load_val - phase length minus one
//   expired  - high in the last cycle of the current phase
module ttl_74193_seq_phase_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Loading length-1 makes a one-cycle phase expire in its first cycle.
    assign expired = (cnt == '0);

endmodule

// File: rtl/ttl_74193_sequencer.sv
// Command sequencer for a 74193 presettable up/down counter.
// Converts a valid/ready command stream (clear, load, count up N, count
// down N) into correctly ordered strobes on the counter pins, keeps a shadow
// copy of the expected count and flags any disagreement with the counter.
// Ports:
//   CP, MR                     - clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready        - command handshake
//   cmd_op/cmd_data/cmd_count  - opcode, load value, pulse count N
//   CNT_MR/CNT_PL_bar/CNT_CPU/CNT_CPD/CNT_D - drive the counter
//   Q, TCU_bar, TCD_bar        - counter feedback used for checking only
//   done                       - one-cycle pulse at command completion
//   shadow_q                   - expected counter value
//   wraps                      - shadow wrap-arounds in the last up/down
//   mismatch                   - sticky counter/shadow disagreement flag
module ttl_74193_sequencer
    import ttl_74193_seq_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int STEP_WIDTH        = 8,
    parameter int PULSE_LOW_CYCLES  = 1,
    parameter int PULSE_HIGH_CYCLES = 1
) (
    input  logic                  CP,
    input  logic                  MR,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic [STEP_WIDTH-1:0] cmd_count,
    output logic                  CNT_MR,
    output logic                  CNT_PL_bar,
    output logic                  CNT_CPU,
    output logic                  CNT_CPD,
    output logic [WIDTH-1:0]      CNT_D,
    input  logic [WIDTH-1:0]      Q,
    input  logic                  TCU_bar,
    input  logic                  TCD_bar,
    output logic                  done,
    output logic [WIDTH-1:0]      shadow_q,
    output logic [STEP_WIDTH-1:0] wraps,
    output logic                  mismatch
);

    localparam int MAX_CYCLES = (PULSE_LOW_CYCLES > PULSE_HIGH_CYCLES) ?
                                PULSE_LOW_CYCLES : PULSE_HIGH_CYCLES;
    // Timer holds length-1, so $clog2(MAX_CYCLES) bits suffice.
    localparam int TMR_W = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [TMR_W-1:0] LOW_RELOAD  = TMR_W'(PULSE_LOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] HIGH_RELOAD = TMR_W'(PULSE_HIGH_CYCLES - 1);

    function automatic logic [STEP_WIDTH-1:0] sat_inc(input logic [STEP_WIDTH-1:0] v);
        return (v == '1) ? v : v + STEP_WIDTH'(1);
    endfunction

    state_t                state, state_n;
    logic                  dir_down, dir_n;
    logic [STEP_WIDTH-1:0] pulses_left;
    logic                  start;
    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_expired;
    logic                  q_differs, tcu_err, tcd_err;

    ttl_74193_seq_phase_timer #(
        .CNT_W (TMR_W)
    ) u_phase_timer (
        .clk      (CP),
        .rst      (MR),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // The counter is cleared both by our own reset and by a CLEAR command.
    assign CNT_MR = MR | (state == ST_CLEAR);

    assign q_differs = (state == ST_DONE) && (Q != shadow_q);
    // Carry/borrow may only be active while the shadow sits at the terminal value.
    assign tcu_err   = !TCU_bar && !CNT_CPU && (shadow_q != '1);
    assign tcd_err   = !TCD_bar && !CNT_CPD && (shadow_q != '0);

    always_comb begin
        state_n  = state;
        dir_n    = dir_down;
        start    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = LOW_RELOAD;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (cmd_valid && cmd_ready) begin
                    start = 1'b1;
                    case (cmd_op)
                        OP_CLEAR: state_n = ST_CLEAR;
                        OP_LOAD:  state_n = ST_LOAD;
                        default: begin
                            dir_n = (cmd_op == OP_DOWN);
                            if (cmd_count == '0) begin
                                state_n = ST_DONE;
                            end else begin
                                state_n  = ST_LOW;
                                tmr_load = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CLEAR, ST_LOAD: state_n = ST_DONE;
            ST_LOW: begin
                if (tmr_expired) begin
                    state_n  = ST_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = HIGH_RELOAD;
                end
            end
            ST_HIGH: begin
                if (tmr_expired) begin
                    if (pulses_left != '0) begin
                        state_n  = ST_LOW;
                        tmr_load = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state       <= ST_IDLE;
            dir_down    <= 1'b0;
            pulses_left <= '0;
            cmd_ready   <= 1'b0;
            done        <= 1'b0;
            CNT_PL_bar  <= 1'b1;
            CNT_CPU     <= 1'b1;
            CNT_CPD     <= 1'b1;
            CNT_D       <= '0;
            shadow_q    <= '0;
            wraps       <= '0;
            mismatch    <= 1'b0;
        end else begin
            state     <= state_n;
            dir_down  <= dir_n;
            // Strobes are registered from the next state so they switch on the
            // same edge that enters the state.
            cmd_ready  <= (state_n == ST_IDLE) || (state_n == ST_DONE);
            done       <= (state_n == ST_DONE);
            CNT_PL_bar <= (state_n != ST_LOAD);
            CNT_CPU    <= !((state_n == ST_LOW) && !dir_n);
            CNT_CPD    <= !((state_n == ST_LOW) && dir_n);

            if (start && (cmd_op == OP_LOAD)) begin
                CNT_D <= cmd_data;
            end
            if (start && ((cmd_op == OP_UP) || (cmd_op == OP_DOWN))) begin
                wraps       <= '0;
                pulses_left <= cmd_count;
            end

            case (state)
                ST_CLEAR: shadow_q <= '0;
                ST_LOAD:  shadow_q <= CNT_D;
                ST_LOW: begin
                    // Leaving LOW is the counter's rising edge.
                    if (tmr_expired) begin
                        pulses_left <= pulses_left - STEP_WIDTH'(1);
                        if (dir_down) begin
                            shadow_q <= shadow_q - WIDTH'(1);
                            if (shadow_q == '0) wraps <= sat_inc(wraps);
                        end else begin
                            shadow_q <= shadow_q + WIDTH'(1);
                            if (shadow_q == '1) wraps <= sat_inc(wraps);
                        end
                    end
                end
                default: ;
            endcase

            if (state == ST_CLEAR) begin
                mismatch <= 1'b0;
            end else if (q_differs || tcu_err || tcd_err) begin
                mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ttl_74193_sequencer.md
# ttl_74193_sequencer

Synchronous command sequencer for the 74193 presettable up/down counter model. It turns a valid/ready command stream (clear, load, count up by N, count down by N) into correctly ordered active-low pulses on the counter's MR, PL_bar, CPU and CPD pins. It keeps a shadow copy of the expected count and checks the counter's Q against it when each command completes. It sits between the processor's control logic and any 74193 chain used as a program counter or loop counter.

## Interface
Parameters:
- WIDTH, 4, counter width; must match the driven 74193.
- STEP_WIDTH, 8, width of the per-command pulse count N.
- PULSE_LOW_CYCLES, 1, CP cycles each CPU/CPD pulse is held low; ≥1.
- PULSE_HIGH_CYCLES, 1, CP cycles each CPU/CPD pulse is held high after rising; ≥1.

Ports:
- CP  in  1  clock; all state changes on the rising edge.
- MR  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 clear, 01 load, 10 up, 11 down.
- cmd_data  in  WIDTH  load value.
- cmd_count  in  STEP_WIDTH  pulse count N for up/down.
- CNT_MR  out  1  to counter MR.
- CNT_PL_bar  out  1  to counter PL_bar.
- CNT_CPU  out  1  to counter CPU.
- CNT_CPD  out  1  to counter CPD.
- CNT_D  out  WIDTH  to counter D.
- Q  in  WIDTH  from counter Q.
- TCU_bar  in  1  from counter (carry).
- TCD_bar  in  1  from counter (borrow).
- done  out  1  one-cycle pulse when a command completes.
- shadow_q  out  WIDTH  expected count.
- wraps  out  STEP_WIDTH  number of shadow wrap-arounds (up or down) during the last up/down command.
- mismatch  out  1  sticky: Q differed from shadow_q at a done.

## Operation
- Reset values (MR high): cmd_ready=0, CNT_PL_bar=1, CNT_CPU=1, CNT_CPD=1, CNT_D=0, done=0, shadow_q=0, wraps=0, mismatch=0, state IDLE.
- CNT_MR = MR OR (state CLEAR). A sequencer reset therefore also clears the counter. MR asserted mid-command aborts the command immediately; no partial pulse is completed.
- States:
  - IDLE: cmd_ready=1. On the handshake, go to CLEAR, LOAD, LOW or DONE (up/down with N=0).
  - CLEAR: one cycle; shadow_q←0, mismatch←0 → DONE.
  - LOAD: one cycle with CNT_PL_bar=0; CNT_D←cmd_data at acceptance; shadow_q←cmd_data → DONE.
  - LOW: active line low for PULSE_LOW_CYCLES → HIGH.
  - HIGH: active line back high. On entry (the counter's rising edge), shadow_q←shadow_q±1 mod 2^WIDTH. Stay PULSE_HIGH_CYCLES, then LOW if pulses remain, else DONE.
  - DONE: done=1, cmd_ready=1. Compare Q to shadow_q; set mismatch if they differ. Accepts a back-to-back command, with the same transitions as IDLE; otherwise → IDLE.
- Direction: up pulses only CNT_CPU, down only CNT_CPD. The inactive line is held 1 throughout. CNT_CPU and CNT_CPD are never low simultaneously.
- wraps is cleared at acceptance of an up/down command. It increments when shadow goes all-ones→0 (up) or 0→all-ones (down), saturating at all-ones.
- CNT_D holds its value until the next load. CNT_PL_bar is low only in LOAD.
- Commands with cmd_valid while cmd_ready=0 are held off and are not dropped. cmd_* must stay stable until the handshake.
- TCU_bar/TCD_bar are used only for checking. If TCU_bar is low while CNT_CPU is low and shadow_q ≠ all-ones, set mismatch. The TCD_bar/CNT_CPD/zero check is symmetric.

## Timing
- All outputs are registered except CNT_MR, which is OR-combined with MR.
- L=PULSE_LOW_CYCLES, H=PULSE_HIGH_CYCLES; handshake at edge E0.
- Clear/load: strobe active E0+1..E0+2; done in cycle E0+2..E0+3.
- Up/down N≥1: pulse k (0..N-1) low from E0+1+k(L+H) for L cycles, then high for H cycles. done in cycle starting E0+1+N(L+H).
- N=0: done at E0+1; no pulses.
- Back-to-back: the next command accepted in a DONE cycle drives its first strobe at the following edge.

## Structure
- Package ttl_74193_seq_pkg: op encoding constants (OP_CLEAR, OP_LOAD, OP_UP, OP_DOWN) and the state enumeration.
- One sub-module, ttl_74193_seq_phase_timer: a loadable down-counter that produces phase-expiry for the LOW/HIGH durations. It is reused for both phases.
- The bench instantiates the sequencer driving a real ttl_74193.

## Test plan
- MR pulse, then clear: CNT_MR high for 1 cycle, done at E0+2, Q=0, shadow_q=0, mismatch=0.
- Load 4'hA, then up N=3 (L=H=1): three CPU lows at E0+1, +3, +5; done at E0+7; Q=shadow_q=4'hD; wraps=0.
- Load 4'hE, up N=5: Q=shadow_q=4'h3, wraps=1, TCU_bar low during the pulse taken from 4'hF.
- Load 4'h1, down N=3, then up N=0 back-to-back: Q=4'hE, wraps=1; second done exactly one cycle after the first; CPU never low.
- Up N=200 with MR asserted mid-pulse: all strobes return high and CNT_MR=1 asynchronously; shadow_q=0; after MR falls, Q=0 and cmd_ready=1.
- Force Q via a bench override to differ at done: mismatch=1 and stays set through later commands until a clear.
